// File: rtl/pixel_sink_buffer.sv
// Tail-of-pipeline pixel collector: raises the global stall, buffers pixels in a FWFT FIFO,
// and tags each output pixel with start-of-frame / end-of-line markers.
package pkg;
  typedef logic [7:0] color_t;
endpackage

module pixel_sink_buffer
  import pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic   clk,
  input  logic   reset,
  input  color_t color_in,
  input  logic   color_in_valid,
  output logic   datapath_ready,
  output color_t pix_out,
  output logic   pix_out_valid,
  input  logic   pix_out_ready,
  output logic   pix_out_sof,
  output logic   pix_out_eol,
  output logic   frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int YW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);
  localparam logic [XW-1:0] C_LAST_COL = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] C_LAST_ROW = YW'(FRAME_LINES - 1);

  color_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic          r_frame_done;

  logic w_wr;
  logic w_rd;
  logic w_last_col;
  logic w_last_row;

  // Stall depends only on registered occupancy, never on the downstream ready.
  assign datapath_ready = ~reset & (r_count != C_FULL);
  assign pix_out_valid  = (r_count != '0);
  assign pix_out        = r_mem[r_rd_ptr];

  assign w_wr       = color_in_valid & datapath_ready;
  assign w_rd       = pix_out_valid & pix_out_ready;
  assign w_last_col = (r_col == C_LAST_COL);
  assign w_last_row = (r_row == C_LAST_ROW);

  assign pix_out_sof = pix_out_valid & (r_row == '0) & (r_col == '0);
  assign pix_out_eol = pix_out_valid & w_last_col;
  assign frame_done  = r_frame_done;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= color_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Frame position tracks the pixel being handed downstream.
      if (w_rd) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      r_frame_done <= w_rd & w_last_col & w_last_row;
    end
  end

endmodule
